axi_rd_slave: RTL and testbench



---
 rtl/axi_pkg.sv | 50 +++++
 rtl/axi_ar_fifo.sv | 66 ++++++
 rtl/axi_rd_slave.sv | 228 ++++++++++++++++++++++
 tb/tb_axi_rd_slave.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared types and constants for the AXI4 read-channel responder.
//   burst_t    : AXI burst encoding (FIXED, INCR, WRAP, RSVD)
//   RESP_*     : RRESP codes
//   ar_req_t   : one queued read-address request
//   rd_state_t : read-data FSM state
// Default widths come from the AWID/AWADDR/WDATA width macros when the
// surrounding build defines them; otherwise local defaults are used.
// -----------------------------------------------------------------------------
`ifndef AWID_WIDTH
`define AWID_WIDTH 4
`endif
`ifndef AWADDR_WIDTH
`define AWADDR_WIDTH 32
`endif
`ifndef WDATA_WIDTH
`define WDATA_WIDTH 32
`endif

package axi_pkg;

    localparam int AR_ID_W   = `AWID_WIDTH;
    localparam int AR_ADDR_W = `AWADDR_WIDTH;
    localparam int AR_DATA_W = `WDATA_WIDTH;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2,
        RSVD  = 2'd3
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [AR_ID_W-1:0]   id;
        logic [AR_ADDR_W-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        burst_t               burst;
    } ar_req_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi_ar_fifo.sv
// -----------------------------------------------------------------------------
// axi_ar_fifo
// Synchronous FIFO of read-address requests (show-ahead: o_rdata is the head).
//   clk, rst        : clock, synchronous active-high reset (empties the queue)
//   i_push, i_wdata : enqueue one request (caller guarantees !o_full)
//   i_pop           : dequeue head (caller guarantees !o_empty)
//   o_rdata         : current head entry
//   o_full, o_empty : occupancy flags
// AR_DEPTH must be a power of two, at least 2.
// -----------------------------------------------------------------------------
module axi_ar_fifo
    import axi_pkg::*;
#(
    parameter int AR_DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_push,
    input  ar_req_t i_wdata,
    input  logic    i_pop,
    output ar_req_t o_rdata,
    output logic    o_full,
    output logic    o_empty
);

    localparam int PW = (AR_DEPTH > 1) ? $clog2(AR_DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(AR_DEPTH);

    ar_req_t       r_mem [AR_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    // Entry storage; contents need no reset since r_count gates visibility.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because depth is 2^PW.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/axi_rd_slave.sv
// -----------------------------------------------------------------------------
// axi_rd_slave
// AXI4 read-channel responder backed by a word-addressed register memory.
//   clk, rst                 : clock, synchronous active-high reset
//   AR* (ARID..ARVALID)      : read-address channel in; ARREADY out
//   R*  (RID..RVALID)        : read-data channel out; RREADY in
//   mem_we/mem_waddr/wdata   : backdoor memory write (lands at the clock edge)
// Requests queue in axi_ar_fifo and are served strictly in order. Each beat is
// computed (address, error, data) at the moment it is loaded into the R
// registers, so later backdoor writes never disturb a presented beat.
// -----------------------------------------------------------------------------
module axi_rd_slave
    import axi_pkg::*;
#(
    parameter int ID_W      = AR_ID_W,
    parameter int ADDR_W    = AR_ADDR_W,
    parameter int DATA_W    = AR_DATA_W,
    parameter int MEM_DEPTH = 1024,
    parameter int AR_DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ID_W-1:0]              ARID,
    input  logic [ADDR_W-1:0]            ARADDR,
    input  logic [7:0]                   ARLEN,
    input  logic [2:0]                   ARSIZE,
    input  logic [1:0]                   ARBURST,
    input  logic [3:0]                   ARREGION,
    input  logic                         ARVALID,
    output logic                         ARREADY,
    output logic [ID_W-1:0]              RID,
    output logic [DATA_W-1:0]            RDATA,
    output logic [1:0]                   RRESP,
    output logic                         RLAST,
    output logic                         RVALID,
    input  logic                         RREADY,
    input  logic                         mem_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
    input  logic [DATA_W-1:0]            mem_wdata
);

    localparam int BSH  = $clog2(DATA_W / 8);
    localparam int MIW  = $clog2(MEM_DEPTH);
    // Wide enough for any word index plus 255 beats, so an overflowing INCR
    // burst compares as out of range instead of wrapping back into memory.
    localparam int BA_W = ADDR_W + 9;

    // Beat address for FIXED / INCR / WRAP. For a legal WRAP, ARLEN+1 is a
    // power of two, so ARLEN itself is the wrap mask.
    function automatic logic [BA_W-1:0] beat_addr(input logic [BA_W-1:0] word,
                                                  input burst_t          burst,
                                                  input logic [7:0]      len,
                                                  input logic [7:0]      beat);
        logic [BA_W-1:0] mask;
        mask = BA_W'(len);
        case (burst)
            FIXED:   beat_addr = word;
            INCR:    beat_addr = word + BA_W'(beat);
            WRAP:    beat_addr = (word & ~mask) | ((word + BA_W'(beat)) & mask);
            default: beat_addr = word;
        endcase
    endfunction

    // Whole-burst error: wrong beat size, reserved burst, or illegal WRAP length.
    function automatic logic burst_err(input ar_req_t req);
        logic wrap_len_ok;
        wrap_len_ok = (req.len == 8'd1) || (req.len == 8'd3) ||
                      (req.len == 8'd7) || (req.len == 8'd15);
        burst_err = (req.size != 3'(BSH)) || (req.burst == RSVD) ||
                    ((req.burst == WRAP) && !wrap_len_ok);
    endfunction

    rd_state_t         r_state, w_state_nxt;
    ar_req_t           r_cur, w_head, w_push_req, w_req;
    logic [7:0]        r_beat, w_ld_beat;
    logic              w_push, w_pop, w_load, w_rhs, w_full, w_empty;
    logic              r_ar_en;
    logic [BA_W-1:0]   w_word, w_addr;
    logic              w_err;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    logic [ID_W-1:0]   r_rid;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;
    logic              r_rlast, r_rvalid;

    logic              w_unused;
    assign w_unused = ^{1'b0, ARREGION};

    assign ARREADY = r_ar_en & ~w_full;
    assign w_push  = ARVALID & ARREADY;
    assign w_rhs   = r_rvalid & RREADY;

    // Pack the incoming address channel into a queue entry.
    always_comb begin
        w_push_req       = '0;
        w_push_req.id    = AR_ID_W'(ARID);
        w_push_req.addr  = AR_ADDR_W'(ARADDR);
        w_push_req.len   = ARLEN;
        w_push_req.size  = ARSIZE;
        w_push_req.burst = burst_t'(ARBURST);
    end

    axi_ar_fifo #(
        .AR_DEPTH (AR_DEPTH)
    ) u_ar_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_push_req),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // ARREADY is held low during reset and rises on the first cycle after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ar_en <= 1'b0;
        end else begin
            r_ar_en <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and beat-load control; IDLE loads beat 0 of the queue head,
    // BURST loads the following beat of the current request.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_req       = r_cur;
        w_ld_beat   = r_beat + 8'd1;
        case (r_state)
            ST_IDLE: begin
                w_req     = w_head;
                w_ld_beat = 8'd0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = ST_BURST;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (w_rhs) begin
                    if (r_rlast) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_load = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_BURST;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Address generation, error classification and asynchronous memory read.
    always_comb begin
        w_word = BA_W'(w_req.addr >> BSH);
        w_addr = beat_addr(w_word, w_req.burst, w_req.len, w_ld_beat);
        w_err  = burst_err(w_req) || (w_addr >= BA_W'(MEM_DEPTH));
        if (w_err) begin
            w_rdata = '0;
        end else begin
            w_rdata = r_mem[w_addr[MIW-1:0]];
        end
    end

    // Backdoor write; a beat loaded on the same edge sees the old word.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            r_mem[mem_waddr] <= mem_wdata;
        end
    end

    // Current request and beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur  <= '0;
            r_beat <= 8'd0;
        end else if (w_load) begin
            r_cur  <= w_req;
            r_beat <= w_ld_beat;
        end
    end

    // R channel output registers; hold steady until the beat is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rid    <= '0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
            r_rlast  <= 1'b0;
        end else if (w_load) begin
            r_rvalid <= 1'b1;
            r_rid    <= ID_W'(w_req.id);
            r_rdata  <= w_rdata;
            r_rresp  <= w_err ? RESP_SLVERR : RESP_OKAY;
            r_rlast  <= (w_ld_beat == w_req.len);
        end else if (w_rhs) begin
            r_rvalid <= 1'b0;
        end
    end

    assign RID    = r_rid;
    assign RDATA  = r_rdata;
    assign RRESP  = r_rresp;
    assign RLAST  = r_rlast;
    assign RVALID = r_rvalid;

endmodule

// File: tb/tb_axi_rd_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_slave
// Self-checking bench for axi_rd_slave. A behavioural model turns each
// accepted AR into a list of expected beats (plain modulo arithmetic over a
// mirror of memory); the R channel is compared to the head of that list on
// every valid cycle, and beat-to-beat / burst-to-burst spacing is checked.
// -----------------------------------------------------------------------------
module tb_axi_rd_slave;

    localparam int DEPTH = 1024;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_t;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic [3:0]  ARREGION;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        mem_we;
    logic [9:0]  mem_waddr;
    logic [31:0] mem_wdata;

    axi_rd_slave #(
        .ID_W      (4),
        .ADDR_W    (32),
        .DATA_W    (32),
        .MEM_DEPTH (DEPTH),
        .AR_DEPTH  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ARID      (ARID),
        .ARADDR    (ARADDR),
        .ARLEN     (ARLEN),
        .ARSIZE    (ARSIZE),
        .ARBURST   (ARBURST),
        .ARREGION  (ARREGION),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .RID       (RID),
        .RDATA     (RDATA),
        .RRESP     (RRESP),
        .RLAST     (RLAST),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mdl_mem [DEPTH];
    ar_t         pend_q [$];
    beat_t       exp_q [$];
    ar_t         cur_ar;
    logic        ar_hs;
    logic        chk_zero;
    logic        chk_one;
    int          cd;
    bit          rand_rdy;
    bit          force_stall;
    int          n_acc;
    int          n_assert;
    int          n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected beats of one burst, straight from the burst rules.
    task automatic model_push(input ar_t a);
        int      n;
        longint  w;
        longint  wa;
        bit      berr;
        beat_t   e;
        n    = int'(a.len) + 1;
        w    = longint'(a.addr) / 4;
        berr = (a.size != 3'd2) || (a.burst == 2'd3) ||
               ((a.burst == 2'd2) && !(n == 2 || n == 4 || n == 8 || n == 16));
        for (int b = 0; b < n; b++) begin
            case (a.burst)
                2'd0:    wa = w;
                2'd1:    wa = w + b;
                default: wa = w - (w % n) + (((w % n) + b) % n);
            endcase
            e.id   = a.id;
            e.last = (b == n - 1);
            if (berr || wa >= DEPTH) begin
                e.resp = 2'b10;
                e.data = 32'd0;
            end else begin
                e.resp = 2'b00;
                e.data = mdl_mem[wa];
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic add_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        ar_t a;
        a.id = id; a.addr = addr; a.len = len; a.size = size; a.burst = burst;
        pend_q.push_back(a);
    endtask

    task automatic clear_state();
        pend_q.delete();
        exp_q.delete();
        ar_hs = 1'b0; chk_zero = 1'b0; chk_one = 1'b0; cd = 0;
    endtask

    // One negedge per iteration: deferred spacing checks, AR driving, R checking.
    task automatic run(input int max_cyc, input int abort_at);
        int    cyc;
        logic  rdy;
        beat_t e;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (chk_zero) begin
                chk("bubble_after_last", 64'(RVALID), 64'd0);
                chk_zero = 1'b0;
            end
            if (chk_one) begin
                chk("no_bubble_in_burst", 64'(RVALID), 64'd1);
                chk_one = 1'b0;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 1) chk("beat0_not_early", 64'(RVALID), 64'd0);
                else         chk("beat0_latency", 64'(RVALID), 64'd1);
            end
            if (abort_at > 0 && cyc >= abort_at) return;
            if (exp_q.size() == 0 && pend_q.size() == 0 && !ARVALID && !ar_hs && cd == 0) return;
            if (cyc > max_cyc) begin
                chk("run_timeout", 64'(cyc), 64'(max_cyc));
                return;
            end
            // AR channel
            if (ar_hs) begin
                ARVALID = 1'b0;
                ar_hs   = 1'b0;
            end
            if (!ARVALID && pend_q.size() > 0) begin
                cur_ar  = pend_q.pop_front();
                ARID    = cur_ar.id;
                ARADDR  = cur_ar.addr;
                ARLEN   = cur_ar.len;
                ARSIZE  = cur_ar.size;
                ARBURST = cur_ar.burst;
                ARVALID = 1'b1;
            end
            if (ARVALID && ARREADY === 1'b1) begin
                if (exp_q.size() == 0) cd = 2;
                model_push(cur_ar);
                ar_hs = 1'b1;
                n_acc++;
            end
            // R channel
            if (RVALID === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(RVALID), 64'd0);
                end else begin
                    chk("rid",   64'(RID),   64'(exp_q[0].id));
                    chk("rdata", 64'(RDATA), 64'(exp_q[0].data));
                    chk("rresp", 64'(RRESP), 64'(exp_q[0].resp));
                    chk("rlast", 64'(RLAST), 64'(exp_q[0].last));
                end
            end
            rdy = force_stall ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
            RREADY = rdy;
            if (RVALID === 1'b1 && rdy && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.last) begin
                    chk_zero = 1'b1;
                    if (exp_q.size() > 0) cd = 2;
                end else begin
                    chk_one = 1'b1;
                end
            end
        end
    endtask

    initial begin
        n_assert = 0; n_fail = 0; n_acc = 0;
        rand_rdy = 1'b0; force_stall = 1'b0;
        clear_state();
        rst = 1'b1;
        ARID = 4'd0; ARADDR = 32'd0; ARLEN = 8'd0; ARSIZE = 3'd0; ARBURST = 2'd0;
        ARREGION = 4'd0; ARVALID = 1'b0; RREADY = 1'b0;
        mem_we = 1'b0; mem_waddr = 10'd0; mem_wdata = 32'd0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_arready", 64'(ARREADY), 64'd0);
        chk("rst_rvalid",  64'(RVALID),  64'd0);
        chk("rst_rlast",   64'(RLAST),   64'd0);
        chk("rst_rid",     64'(RID),     64'd0);
        chk("rst_rdata",   64'(RDATA),   64'd0);
        chk("rst_rresp",   64'(RRESP),   64'd0);

        // Backdoor preload: words 0..15 hold their index, the rest random
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            mdl_mem[i] = (i < 16) ? 32'(i) : $urandom;
            mem_we     = 1'b1;
            mem_waddr  = 10'(i);
            mem_wdata  = mdl_mem[i];
        end
        @(negedge clk);
        mem_we = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
        chk("arready_after_reset", 64'(ARREADY), 64'd1);

        // INCR word 0 len 3, then WRAP word 6 len 3, FIXED word 9 len 2
        add_ar(4'd1, 32'h0, 8'd3, 3'd2, 2'd1);
        run(100, 0);
        add_ar(4'd2, 32'd24, 8'd3, 3'd2, 2'd2);
        add_ar(4'd3, 32'd36, 8'd2, 3'd2, 2'd0);
        run(100, 0);

        // Running off the end of memory, and a reserved burst type
        add_ar(4'd4, 32'((DEPTH - 2) * 4), 8'd3, 3'd2, 2'd1);
        add_ar(4'd5, 32'd40, 8'd1, 3'd2, 2'd3);
        run(100, 0);

        // Back-to-back ARs while R is stalled: queue fills, then drains in order
        force_stall = 1'b1;
        n_acc = 0;
        add_ar(4'd7, 32'd0,  8'd1, 3'd2, 2'd1);
        add_ar(4'd8, 32'd16, 8'd2, 3'd2, 2'd1);
        add_ar(4'd9, 32'd32, 8'd0, 3'd2, 2'd0);
        add_ar(4'd10, 32'd48, 8'd1, 3'd2, 2'd1);
        run(100, 8);
        chk("ar_accepted_while_stalled", 64'(n_acc), 64'd3);
        chk("arready_when_full", 64'(ARREADY), 64'd0);
        force_stall = 1'b0;
        run(200, 0);

        // Randomized traffic with random RREADY back-pressure
        rand_rdy = 1'b1;
        for (int k = 0; k < 14; k++) begin
            ar_t a;
            int  sel;
            sel     = $urandom_range(0, 9);
            a.id    = 4'($urandom_range(0, 15));
            a.burst = (sel == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a.size  = (sel == 1) ? 3'd1 : 3'd2;
            case ($urandom_range(0, 3))
                0:       a.len = 8'd3;
                1:       a.len = 8'd7;
                2:       a.len = 8'd15;
                default: a.len = 8'($urandom_range(0, 12));
            endcase
            a.addr = 32'((($urandom_range(0, 1) == 1) ? $urandom_range(0, DEPTH - 1)
                                                      : $urandom_range(DEPTH - 14, DEPTH + 6)) * 4
                         + $urandom_range(0, 3));
            pend_q.push_back(a);
        end
        add_ar(4'd11, 32'(900 * 4), 8'd255, 3'd2, 2'd1);
        run(5000, 0);

        // Reset in the middle of a burst
        add_ar(4'd5, 32'(100 * 4), 8'd20, 3'd2, 2'd1);
        run(200, 6);
        rst     = 1'b1;
        ARVALID = 1'b0;
        RREADY  = 1'b0;
        clear_state();
        @(negedge clk);
        chk("midrst_arready", 64'(ARREADY), 64'd0);
        chk("midrst_rvalid",  64'(RVALID),  64'd0);
        chk("midrst_rlast",   64'(RLAST),   64'd0);
        chk("midrst_rid",     64'(RID),     64'd0);
        chk("midrst_rdata",   64'(RDATA),   64'd0);
        chk("midrst_rresp",   64'(RRESP),   64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_arready", 64'(ARREADY), 64'd1);
        chk("post_rst_rvalid",  64'(RVALID),  64'd0);
        rand_rdy = 1'b0;
        add_ar(4'd6, 32'd12, 8'd3, 3'd2, 2'd1);
        run(100, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
